// File: rtl/mips_mem_responder.sv
// Memory-side responder for the pipelined MIPS core: IMEM/DMEM word arrays,
// a preload port that fills both while the core is held in reset, and access checking.
module mips_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int RESET_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           inst_addr,
  output logic [31:0]           inst,
  input  logic [31:0]           data_addr,
  input  logic [31:0]           data_out,
  input  logic                  data_wr,
  output logic [31:0]           data_in,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic                  ld_sel,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [31:0]           ld_data,
  input  logic                  ld_last,
  output logic                  cpu_rst_n,
  output logic                  running,
  output logic                  err,
  output logic [31:0]           err_addr,
  output logic [15:0]           wr_count,
  output logic [1:0]            fsm_state
);

  // Preload handshake: a word transfers on any rising edge where ld_valid and
  // ld_ready are both high; ld_ready is high only in LOAD, and the source may
  // hold ld_valid indefinitely without side effects in any other state.

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int HW    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  logic [31:0] imem [DEPTH];
  logic [31:0] dmem [DEPTH];

  state_t          state, state_next;
  logic [HW-1:0]   hold_cnt;
  logic            ld_fire;
  logic            inst_ok, data_in_range, store_ok, store_err, fetch_err;
  logic [ADDR_WIDTH-1:0] inst_idx, data_idx;

  assign inst_idx      = inst_addr[ADDR_WIDTH+1:2];
  assign data_idx      = data_addr[ADDR_WIDTH+1:2];
  assign inst_ok       = (inst_addr[31:ADDR_WIDTH+2] == '0) && (inst_addr[1:0] == 2'b00);
  assign data_in_range = (data_addr[31:ADDR_WIDTH+2] == '0);

  assign ld_fire   = ld_valid && ld_ready;
  assign store_ok  = (state == S_RUN) && data_wr && data_in_range && (data_addr[1:0] == 2'b00);
  assign store_err = (state == S_RUN) && data_wr && !(data_in_range && (data_addr[1:0] == 2'b00));
  assign fetch_err = (state == S_RUN) && !inst_ok;

  // Reads are combinational; the core latches them at its own MEM/IF edge.
  assign inst    = inst_ok ? imem[inst_idx] : 32'h0;
  assign data_in = data_in_range ? dmem[data_idx] : 32'h0;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_LOAD: if (ld_fire && ld_last) state_next = S_HOLD;
      S_HOLD: if (hold_cnt == HW'(RESET_HOLD - 1)) state_next = S_RUN;
      S_RUN:  state_next = S_RUN;
      default: state_next = S_LOAD;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ld_ready  = (state == S_LOAD);
    fsm_state = state;
  end

  // Core reset and running flag are flops fed from next-state so they are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rst_n <= 1'b0;
      running   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      cpu_rst_n <= (state_next == S_RUN);
      running   <= (state_next == S_RUN);
      hold_cnt  <= (state == S_HOLD) ? hold_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      err_addr <= 32'h0;
      wr_count <= 16'h0;
    end else begin
      if (!err && (store_err || fetch_err)) begin
        err      <= 1'b1;
        err_addr <= store_err ? data_addr : inst_addr;
      end
      if (store_ok && wr_count != 16'hFFFF) wr_count <= wr_count + 16'h1;
    end
  end

  // Arrays are deliberately not reset so preloaded code survives rst_n.
  always_ff @(posedge clk) begin
    if (ld_fire && !ld_sel) imem[ld_addr] <= ld_data;
    if (ld_fire && ld_sel)       dmem[ld_addr]  <= ld_data;
    else if (store_ok)           dmem[data_idx] <= data_out;
  end

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Memory-side responder for the pipelined MIPS core. It serves the core's instruction-fetch port (inst_addr/inst) and data port (data_addr/data_out/data_wr/data_in) from two word arrays, IMEM and DMEM.
- Reads are combinational, so the core latches data_in at the same edge as its MEM stage. Writes are synchronous.
- A preload handshake port fills both memories while the block holds the core in reset, then releases the core after a fixed delay.
- Address legality is checked on stores and fetches; the block keeps a sticky error and a store counter.

Parameters:
ADDR_WIDTH, 10, word-index width; each memory is 2**ADDR_WIDTH 32-bit words
RESET_HOLD, 4, cycles spent in HOLD before the core is released (min 1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
inst_addr  in  32  core fetch byte address
inst  out  32  fetched instruction
data_addr  in  32  core data byte address
data_out  in  32  core store data
data_wr  in  1  core store strobe
data_in  out  32  load data to core
ld_valid  in  1  preload word valid
ld_ready  out  1  preload word accepted when high with ld_valid
ld_sel  in  1  preload target: 0=IMEM, 1=DMEM
ld_addr  in  ADDR_WIDTH  preload word index
ld_data  in  32  preload word
ld_last  in  1  marks final preload word
cpu_rst_n  out  1  reset to core, active-low
running  out  1  high in RUN
err  out  1  sticky access error
err_addr  out  32  byte address of the first error
wr_count  out  16  accepted core stores, saturating

Behaviour:
- Reset values: state=LOAD, ld_ready=1, cpu_rst_n=0, running=0, err=0, err_addr=0, wr_count=0, hold counter=0. Memory arrays are not reset and keep their contents across rst_n.
- FSM LOAD:
  - ld_ready=1.
  - On ld_valid&ld_ready, ld_data is written at the clock edge to IMEM[ld_addr] (ld_sel=0) or DMEM[ld_addr] (ld_sel=1).
  - If ld_last is set on that transfer, go to HOLD. ld_ready is 0 from the next cycle.
  - ld_last without ld_valid has no effect.
- FSM HOLD:
  - ld_ready=0; the counter increments each cycle.
  - When the counter reaches RESET_HOLD-1, go to RUN. cpu_rst_n and running go to 1 at that same edge.
  - Net effect: exactly RESET_HOLD cycles in HOLD.
- FSM RUN:
  - Terminal until rst_n is asserted.
  - ld_ready=0; ld_valid is ignored and no preload write occurs.
- Register requirements: cpu_rst_n and running are registered (glitch-free). Asserting rst_n at any time forces cpu_rst_n=0 asynchronously and returns the FSM to LOAD, including mid-load and mid-HOLD.
- Fetch: inst = IMEM[inst_addr[ADDR_WIDTH+1:2]], combinational in every state.
  - If inst_addr[31:ADDR_WIDTH+2] != 0 or inst_addr[1:0] != 0, inst=0 (NOP).
  - In RUN only, that fetch is an error.
- Load path: data_in = DMEM[data_addr[ADDR_WIDTH+1:2]], combinational. Out of range gives data_in=0.
  - A load never flags an error, because data_addr carries ALU results on non-memory instructions.
  - Word layout is big-endian: byte 0 is data_in[31:24].
- Store: in RUN with data_wr=1, data_addr[1:0]==0 and data_addr in range, DMEM[idx] <= data_out at the edge, and wr_count increments, saturating at 16'hFFFF.
  - Misaligned or out-of-range store: write is suppressed and the store is an error.
  - data_wr outside RUN is ignored, with no error.
- Read-during-write: data_in shows the old word in the cycle of the write and the new word from the next cycle.
- Error capture: on the first error, err <= 1 and err_addr <= the offending address (data_addr for a store, inst_addr for a fetch). Later errors leave err_addr unchanged. Only rst_n clears err.
- Same-cycle fetch and store errors: err_addr takes data_addr.

Test Plan:
- Preload IMEM[0..2]=0x20080005,0x20090007,0x01095020 (ld_last on idx 2), RESET_HOLD=4 -> ld_ready falls the cycle after the last transfer; cpu_rst_n rises exactly 4 cycles later; inst_addr=0x8 gives inst=0x01095020.
- RUN, data_wr=1, data_addr=0x10, data_out=0xDEADBEEF -> same cycle data_in=old value; next cycle data_in=0xDEADBEEF; wr_count=1.
- RUN, store to 0x13, then a store to 0x5000 (ADDR_WIDTH=10) -> neither written; err=1; err_addr stays 0x13; wr_count unchanged.
- RUN, inst_addr=0x00001000 -> inst=0, err=1, err_addr=0x1000. Load with data_addr=0xFFFFFFF0 -> data_in=0, no error.
- RUN, ld_valid=1 with ld_sel=0, ld_addr=0 -> ld_ready=0, IMEM[0] unchanged; data_wr pulsed while in HOLD -> no write, no count.
- Assert rst_n low mid-HOLD, then release -> cpu_rst_n=0 immediately; state LOAD with ld_ready=1; preloaded words still readable; err and wr_count cleared.
